mul_div_unit: RTL and testbench

//  Iterative 16-bit unsigned multiply/divide execute unit for the 16-bit MIPS datapath.

---
 rtl/mips_pkg.sv | 16 +
 rtl/muldiv_iter_core.sv | 75 +++++++
 rtl/mul_div_unit.sv | 117 +++++++++++
 tb/tb_mul_div_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the 16-bit MIPS datapath execute units.
// Holds the MULU/DIVU opcode encoding, the multiply/divide FSM state
// encoding and the default datapath widths.
package mips_pkg;

    localparam int DATA_W_DEFAULT     = 16;
    localparam int REG_ADDR_W_DEFAULT = 3;

    localparam logic OP_MULU = 1'b0;
    localparam logic OP_DIVU = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

endpackage

// File: rtl/muldiv_iter_core.sv
// Radix-2 iterative datapath shared by MULU and DIVU.
// init loads the operands, each step performs one iteration.
// MULU: shift-add on a 2*DATA_W accumulator whose low half starts as the
// multiplier and whose high half collects partial sums.
// DIVU: restoring divide; the low accumulator half starts as the dividend and
// fills with quotient bits while the partial remainder evolves beside it.
module muldiv_iter_core
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init,
    input  logic              step,
    input  logic              op,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic [DATA_W-1:0] result_lo,
    output logic [DATA_W-1:0] result_hi
);

    logic                  op_q;
    logic [DATA_W-1:0]     opnd_b;
    logic [2*DATA_W-1:0]   acc;
    logic [DATA_W-1:0]     rem;

    logic [DATA_W:0]       mul_sum;
    logic [DATA_W:0]       div_shift;
    logic [DATA_W:0]       div_trial;
    logic [2*DATA_W-1:0]   acc_next;
    logic [DATA_W-1:0]     rem_next;

    // One iteration of either algorithm. The partial remainder is DATA_W+1
    // bits wide while shifted and trial-subtracted; the restored value always
    // fits back into DATA_W bits because it is smaller than the divisor.
    always_comb begin
        mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd_b} : '0);
        div_shift = {rem, acc[DATA_W-1]};
        div_trial = div_shift - {1'b0, opnd_b};
        acc_next  = acc;
        rem_next  = rem;
        if (op_q == OP_MULU) begin
            acc_next = {mul_sum, acc[DATA_W-1:1]};
        end else if (!div_trial[DATA_W]) begin
            rem_next = div_trial[DATA_W-1:0];
            acc_next = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-2:0], 1'b1};
        end else begin
            rem_next = div_shift[DATA_W-1:0];
            acc_next = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-2:0], 1'b0};
        end
    end

    // Operand capture on init, iteration on step, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q   <= OP_MULU;
            opnd_b <= '0;
            acc    <= '0;
            rem    <= '0;
        end else if (init) begin
            op_q   <= op;
            opnd_b <= operand_b;
            acc    <= {{DATA_W{1'b0}}, operand_a};
            rem    <= '0;
        end else if (step) begin
            acc <= acc_next;
            rem <= rem_next;
        end
    end

    assign result_lo = acc[DATA_W-1:0];
    assign result_hi = (op_q == OP_DIVU) ? rem : acc[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/mul_div_unit.sv
// Iterative unsigned MULU/DIVU execute unit for the 16-bit MIPS datapath.
// Accepts a request in IDLE, runs DATA_W radix-2 iterations, then holds a
// writeback request to the RegisterFile until the write port grants it.
// hi_out/div_zero reflect the last op whose writeback completed.
module mul_div_unit
    import mips_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  op,
    input  logic [DATA_W-1:0]     operand_a,
    input  logic [DATA_W-1:0]     operand_b,
    input  logic [REG_ADDR_W-1:0] dest_reg,
    output logic                  busy,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [REG_ADDR_W-1:0] wb_reg,
    output logic [DATA_W-1:0]     wb_data,
    output logic [DATA_W-1:0]     hi_out,
    output logic                  div_zero,
    output logic                  done
);

    localparam int                CNT_W      = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_COUNT = CNT_W'(DATA_W - 1);

    logic [1:0]            state;
    logic [CNT_W-1:0]      count;
    logic [REG_ADDR_W-1:0] dest_q;
    logic                  dz_flag;
    logic                  accept;
    logic                  handshake;
    logic [DATA_W-1:0]     core_lo;
    logic [DATA_W-1:0]     core_hi;

    assign accept    = (state == ST_IDLE) && start;
    assign handshake = (state == ST_WB) && wb_ready;

    muldiv_iter_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .init      (accept),
        .step      (state == ST_RUN),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .result_lo (core_lo),
        .result_hi (core_hi)
    );

    // Control FSM and iteration counter; start is only looked at in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        count <= '0;
                    end
                end
                ST_RUN: begin
                    count <= count + CNT_W'(1);
                    if (count == LAST_COUNT) begin
                        state <= ST_WB;
                    end
                end
                ST_WB: begin
                    if (wb_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Request bookkeeping captured at accept: destination and divide-by-zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dest_q  <= '0;
            dz_flag <= 1'b0;
        end else if (accept) begin
            dest_q  <= dest_reg;
            dz_flag <= (op == OP_DIVU) && (operand_b == '0);
        end
    end

    // Architectural side results update only when the writeback is granted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_out   <= '0;
            div_zero <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= handshake;
            if (handshake) begin
                hi_out   <= core_hi;
                div_zero <= dz_flag;
            end
        end
    end

    assign busy     = (state != ST_IDLE);
    assign wb_valid = (state == ST_WB);
    assign wb_reg   = dest_q;
    assign wb_data  = core_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes hand-computed results,
// a negedge monitor pops them on each writeback handshake and also checks
// hi_out/div_zero/done afterwards and a RegisterFile model readback.
module tb_mul_div_unit;
    import mips_pkg::*;

    localparam int W  = 16;
    localparam int RW = 3;

    typedef struct {
        logic [RW-1:0] reg_idx;
        logic [W-1:0]  data;
        logic [W-1:0]  hi;
        logic          dz;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          op = 1'b0;
    logic [W-1:0]  operand_a = '0;
    logic [W-1:0]  operand_b = '0;
    logic [RW-1:0] dest_reg = '0;
    logic          wb_ready = 1'b1;
    logic          busy;
    logic          wb_valid;
    logic [RW-1:0] wb_reg;
    logic [W-1:0]  wb_data;
    logic [W-1:0]  hi_out;
    logic          div_zero;
    logic          done;

    exp_t sb[$];
    exp_t cur;
    logic pend = 1'b0;
    logic pend_done_chk = 1'b0;
    int   total = 0;
    int   passed = 0;
    int   wb_seen = 0;
    int   lat;

    logic [W-1:0]  rf [8];
    logic [RW-1:0] read_register_1;
    logic [W-1:0]  read_data_1;

    always #5 clk = ~clk;

    mul_div_unit #(.DATA_W(W), .REG_ADDR_W(RW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .dest_reg  (dest_reg),
        .busy      (busy),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_reg    (wb_reg),
        .wb_data   (wb_data),
        .hi_out    (hi_out),
        .div_zero  (div_zero),
        .done      (done)
    );

    // RegisterFile model hooked to the writeback port
    always @(posedge clk) begin
        if (wb_valid && wb_ready) rf[wb_reg] <= wb_data;
    end
    assign read_data_1 = rf[read_register_1];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Monitor: pop the scoreboard on every writeback handshake
    always @(negedge clk) begin
        if (pend_done_chk) begin
            check_output("done_one_cycle", done, 1'b0);
            pend_done_chk = 1'b0;
        end
        if (pend) begin
            check_output("hi_out", hi_out, cur.hi);
            check_output("div_zero", div_zero, cur.dz);
            check_output("done_pulse", done, 1'b1);
            check_output("rf_readback", read_data_1, cur.data);
            pend = 1'b0;
            pend_done_chk = 1'b1;
        end
        if (wb_valid && wb_ready) begin
            wb_seen++;
            if (sb.size() == 0) begin
                check_output("unexpected_wb", 1'b1, 1'b0);
            end else begin
                cur = sb.pop_front();
                check_output("wb_reg", wb_reg, cur.reg_idx);
                check_output("wb_data", wb_data, cur.data);
                read_register_1 = cur.reg_idx;
                pend = 1'b1;
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 60 && busy; i++) begin
            @(posedge clk); #1;
        end
        if (busy) check_output("idle_timeout", busy, 1'b0);
    endtask

    task automatic wait_wb_valid(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            n++;
            if (wb_valid) return;
        end
        check_output("wb_valid_timeout", wb_valid, 1'b1);
    endtask

    task automatic apply_stimulus(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [RW-1:0] d, input logic [W-1:0] lo,
                                  input logic [W-1:0] hi, input logic dz, input bit push);
        exp_t e;
        wait_idle();
        op = o; operand_a = a; operand_b = b; dest_reg = d; start = 1'b1;
        if (push) begin
            e.reg_idx = d; e.data = lo; e.hi = hi; e.dz = dz;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
        check_output("busy_after_accept", busy, 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset state
        @(posedge clk); #1;
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_wb_valid", wb_valid, 1'b0);
        check_output("rst_wb_data", wb_data, 16'h0);
        check_output("rst_hi_out", hi_out, 16'h0);
        check_output("rst_done", done, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: MULU 20*3, latency check
        apply_stimulus(OP_MULU, 16'd20, 16'd3, 3'd4, 16'd60, 16'd0, 1'b0, 1);
        wait_wb_valid(lat);
        check_output("latency", lat, 16);

        // 2: MULU max*max
        apply_stimulus(OP_MULU, 16'hFFFF, 16'hFFFF, 3'd1, 16'h0001, 16'hFFFE, 1'b0, 1);

        // 3: DIVU normal and by zero
        apply_stimulus(OP_DIVU, 16'd100, 16'd7, 3'd2, 16'd14, 16'd2, 1'b0, 1);
        apply_stimulus(OP_DIVU, 16'h1234, 16'h0000, 3'd3, 16'hFFFF, 16'h1234, 1'b1, 1);

        // 4: writeback stall with wb_ready low
        wait_idle();
        wb_ready = 1'b0;
        apply_stimulus(OP_MULU, 16'd300, 16'd200, 3'd5, 16'hEA60, 16'h0000, 1'b0, 1);
        wait_wb_valid(lat);
        for (int i = 0; i < 5; i++) begin
            check_output("stall_wb_valid", wb_valid, 1'b1);
            check_output("stall_wb_reg", wb_reg, 3'd5);
            check_output("stall_wb_data", wb_data, 16'hEA60);
            check_output("stall_busy", busy, 1'b1);
            check_output("stall_hi_out", hi_out, 16'h1234);
            @(posedge clk); #1;
        end
        wb_ready = 1'b1;

        // 5: start during RUN and on the handshake edge is ignored
        apply_stimulus(OP_DIVU, 16'd1000, 16'd7, 3'd6, 16'd142, 16'd6, 1'b0, 1);
        repeat (5) begin @(posedge clk); #1; end
        op = OP_MULU; operand_a = 16'd7; operand_b = 16'd7; dest_reg = 3'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_wb_valid(lat);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_output("no_accept_on_hs_busy", busy, 1'b0);
        check_output("no_accept_on_hs_valid", wb_valid, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        check_output("not_queued_busy", busy, 1'b0);

        // 6: reset mid-RUN aborts
        apply_stimulus(OP_MULU, 16'd9, 16'd9, 3'd1, 16'd81, 16'd0, 1'b0, 0);
        repeat (8) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_output("abort_busy", busy, 1'b0);
        check_output("abort_wb_valid", wb_valid, 1'b0);
        check_output("abort_wb_reg", wb_reg, 3'd0);
        check_output("abort_wb_data", wb_data, 16'h0);
        check_output("abort_hi_out", hi_out, 16'h0);
        check_output("abort_div_zero", div_zero, 1'b0);
        check_output("abort_done", done, 1'b0);
        apply_stimulus(OP_MULU, 16'd5, 16'd5, 3'd7, 16'd25, 16'd0, 1'b0, 1);

        wait_idle();
        repeat (40) begin @(posedge clk); #1; end
        check_output("scoreboard_empty", sb.size(), 0);
        check_output("writeback_count", wb_seen, 7);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
